// File: rtl/weight_tile_sender.sv
`default_nettype none
// ============================================================================
// Module      : weight_tile_sender
// Description : Streams MUL_SIZE-row weight tiles from weight memory to a
//               weight FIFO. Each tile is an unbroken burst of MUL_SIZE row
//               reads, started when the FIFO requests data. Row data is
//               forwarded on a registered output two cycles after each read.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_tile_sender #(
  parameter int MUL_SIZE = 8,
  parameter int W_BITS   = 8,
  parameter int ADDR_W   = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [ADDR_W-1:0]          base_addr_i,
  input  logic [7:0]                 num_tiles_i,
  input  logic                       request_data_i,
  output logic                       mem_rd_en_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic [MUL_SIZE*W_BITS-1:0] mem_data_i,
  output logic [MUL_SIZE*W_BITS-1:0] data_o,
  output logic                       sending_data_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int ROW_W = (MUL_SIZE > 1) ? $clog2(MUL_SIZE) : 1;
  localparam int DW    = MUL_SIZE * W_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_BURST = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;      // running row address, also drives mem_addr_o
  logic [7:0]          tiles_q;     // tiles still to read, including the current one
  logic [ROW_W-1:0]    row_q;       // row index inside the current tile
  logic                rd_en_q;
  logic                rd_dly_q;    // memory data is valid on mem_data_i this cycle
  logic [DW-1:0]       data_q;
  logic                send_q;
  logic                busy_q;
  logic                done_q;

  logic [ADDR_W-1:0]   addr_d;
  logic                last_row_w;
  logic                more_tiles_w;

  // Address wraps naturally at 2^ADDR_W; tiles are contiguous in memory.
  assign addr_d       = addr_q + 1'b1;
  assign last_row_w   = (row_q == ROW_W'(MUL_SIZE - 1));
  assign more_tiles_w = (tiles_q > 8'd1);

  // Control FSM: job acceptance, tile bursts with back-to-back chaining,
  // and completion once the output pipeline has emptied.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      tiles_q <= '0;
      row_q   <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // busy trails the state by one cycle so it covers the done cycle,
      // which the FSM already spends back in IDLE.
      busy_q <= (state_q != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            addr_q  <= base_addr_i;
            tiles_q <= num_tiles_i;
            row_q   <= '0;
            state_q <= (num_tiles_i == 8'd0) ? ST_DRAIN : ST_ARM;
          end
        end
        ST_ARM: begin
          if (request_data_i) begin
            state_q <= ST_BURST;
            rd_en_q <= 1'b1;
          end
        end
        ST_BURST: begin
          addr_q <= addr_d;
          row_q  <= row_q + 1'b1;
          if (last_row_w) begin
            row_q   <= '0;
            tiles_q <= tiles_q - 8'd1;
            if (more_tiles_w && request_data_i) begin
              state_q <= ST_BURST;
              rd_en_q <= 1'b1;
            end else if (more_tiles_w) begin
              state_q <= ST_ARM;
              rd_en_q <= 1'b0;
            end else begin
              state_q <= ST_DRAIN;
              rd_en_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          // With no read data in flight, the final beat (if any) is on
          // the output this cycle, so done lands on the following cycle.
          if (!rd_dly_q) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Output pipeline: align with memory latency, then register the row.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_dly_q <= 1'b0;
      send_q   <= 1'b0;
      data_q   <= '0;
    end else begin
      rd_dly_q <= rd_en_q;
      send_q   <= rd_dly_q;
      if (rd_dly_q) begin
        data_q <= mem_data_i;
      end
    end
  end

  assign mem_rd_en_o    = rd_en_q;
  assign mem_addr_o     = addr_q;
  assign data_o         = data_q;
  assign sending_data_o = send_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_tile_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_tile_sender
// Description : Directed bench for weight_tile_sender (MUL_SIZE=4) with a
//               one-cycle-latency memory model and a cycle-stamped monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_tile_sender;

  localparam int MS = 4;
  localparam int WB = 8;
  localparam int AW = 12;
  localparam int DW = MS * WB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_addr_i = '0;
  logic [7:0]    num_tiles_i = '0;
  logic          request_data_i = 1'b0;
  logic          mem_rd_en_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_i = '0;
  logic [DW-1:0] data_o;
  logic          sending_data_o;
  logic          busy_o;
  logic          done_o;

  weight_tile_sender #(.MUL_SIZE(MS), .W_BITS(WB), .ADDR_W(AW)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .num_tiles_i    (num_tiles_i),
    .request_data_i (request_data_i),
    .mem_rd_en_o    (mem_rd_en_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_i     (mem_data_i),
    .data_o         (data_o),
    .sending_data_o (sending_data_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents as a fixed function of the row address.
  function automatic logic [DW-1:0] row_of(input logic [AW-1:0] a);
    return {a[7:0] ^ 8'h5A, a[7:0] + 8'd3, ~a[7:0], a[3:0], a[11:8]};
  endfunction

  // Memory model: data valid the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en_o) mem_data_i <= row_of(mem_addr_o);
  end

  // Monitor logs
  logic [AW-1:0] rd_addr[$];
  int            rd_cyc[$];
  logic [DW-1:0] bt_data[$];
  int            bt_cyc[$];
  int            done_cyc[$];
  int            busy_cnt;

  always @(negedge clk) begin
    if (mem_rd_en_o) begin rd_addr.push_back(mem_addr_o); rd_cyc.push_back(cyc); end
    if (sending_data_o) begin bt_data.push_back(data_o); bt_cyc.push_back(cyc); end
    if (done_o) done_cyc.push_back(cyc);
    if (busy_o) busy_cnt++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    rd_addr.delete(); rd_cyc.delete(); bt_data.delete(); bt_cyc.delete();
    done_cyc.delete(); busy_cnt = 0;
  endtask

  task automatic start_job(input logic [AW-1:0] base, input logic [7:0] tiles, output int k);
    @(negedge clk);
    clear_logs();
    base_addr_i = base;
    num_tiles_i = tiles;
    start_i = 1'b1;
    k = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done_cyc.size() == 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", 64'(done_cyc.size() != 0), 64'd1);
    repeat (6) @(negedge clk);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [7:0]    tiles;
    int            n_reads;
    logic [AW-1:0] last_addr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int k;
    int raise;
    int nd;
    logic [AW-1:0] ea;

    vecs[0] = '{12'h010, 8'd1, 4,  12'h013};
    vecs[1] = '{12'h010, 8'd3, 12, 12'h01B};
    vecs[2] = '{12'hFFE, 8'd1, 4,  12'h001};
    vecs[3] = '{12'h200, 8'd0, 0,  12'h000};
    vecs[4] = '{12'hFFC, 8'd2, 8,  12'h003};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_rd_en",   64'(mem_rd_en_o),    64'd0);
    chk("rst_addr",    64'(mem_addr_o),     64'd0);
    chk("rst_data",    64'(data_o),         64'd0);
    chk("rst_sending", 64'(sending_data_o), 64'd0);
    chk("rst_busy",    64'(busy_o),         64'd0);
    chk("rst_done",    64'(done_o),         64'd0);
    rst_n = 1'b1;
    request_data_i = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven jobs with request held high
    for (int v = 0; v < 5; v++) begin
      start_job(vecs[v].base, vecs[v].tiles, k);
      wait_done();
      chk("n_reads", 64'(rd_addr.size()), 64'(vecs[v].n_reads));
      chk("n_beats", 64'(bt_data.size()), 64'(vecs[v].n_reads));
      chk("n_done",  64'(done_cyc.size()), 64'd1);
      if (rd_addr.size() == vecs[v].n_reads && bt_data.size() == vecs[v].n_reads) begin
        for (int i = 0; i < vecs[v].n_reads; i++) begin
          ea = vecs[v].base + AW'(i);
          chk("rd_addr",  64'(rd_addr[i]), 64'(ea));
          chk("rd_cycle", 64'(rd_cyc[i]),  64'(k + 2 + i));
          chk("bt_cycle", 64'(bt_cyc[i]),  64'(rd_cyc[i] + 2));
          chk("bt_data",  64'(bt_data[i]), 64'(row_of(ea)));
        end
        if (vecs[v].n_reads > 0) begin
          chk("last_addr", 64'(rd_addr[vecs[v].n_reads-1]), 64'(vecs[v].last_addr));
          chk("data_hold", 64'(data_o), 64'(row_of(vecs[v].last_addr)));
        end
      end
      if (done_cyc.size() == 1) begin
        nd = (vecs[v].n_reads > 0 && bt_cyc.size() > 0) ? bt_cyc[bt_cyc.size()-1] + 1 : k + 2;
        chk("done_cycle", 64'(done_cyc[0]), 64'(nd));
        chk("busy_cycles", 64'(busy_cnt), 64'(done_cyc[0] - k - 1));
      end
      if (vecs[v].n_reads == 0) chk("busy_zero_tile", 64'(busy_cnt), 64'd1);
    end

    // Request drops mid-tile: tile 0 finishes, FSM parks in ARM
    start_job(12'h020, 8'd2, k);
    repeat (2) @(negedge clk);
    request_data_i = 1'b0;
    repeat (5) @(negedge clk);
    request_data_i = 1'b1;
    raise = cyc;
    wait_done();
    chk("gap_n_reads", 64'(rd_addr.size()), 64'd8);
    chk("gap_n_beats", 64'(bt_data.size()), 64'd8);
    chk("gap_n_done",  64'(done_cyc.size()), 64'd1);
    if (rd_cyc.size() == 8) begin
      chk("gap_row1_cycle",  64'(rd_cyc[1]),  64'(k + 3));
      chk("gap_row3_cycle",  64'(rd_cyc[3]),  64'(k + 5));
      chk("gap_tile1_cycle", 64'(rd_cyc[4]),  64'(raise + 1));
      chk("gap_tile1_addr",  64'(rd_addr[4]), 64'h024);
      chk("gap_last_addr",   64'(rd_addr[7]), 64'h027);
    end

    // Reset during the third burst cycle
    start_job(12'h030, 8'd2, k);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en",   64'(mem_rd_en_o),    64'd0);
    chk("mid_rst_addr",    64'(mem_addr_o),     64'd0);
    chk("mid_rst_data",    64'(data_o),         64'd0);
    chk("mid_rst_sending", 64'(sending_data_o), 64'd0);
    chk("mid_rst_busy",    64'(busy_o),         64'd0);
    chk("mid_rst_done",    64'(done_o),         64'd0);
    clear_logs();
    repeat (3) @(negedge clk);
    chk("rst_no_reads", 64'(rd_addr.size()),  64'd0);
    chk("rst_no_beats", 64'(bt_data.size()),  64'd0);
    chk("rst_no_done",  64'(done_cyc.size()), 64'd0);
    // Release and start in the same cycle
    clear_logs();
    rst_n = 1'b1;
    base_addr_i = 12'h040;
    num_tiles_i = 8'd1;
    start_i = 1'b1;
    k = cyc;
    @(negedge clk);
    start_i = 1'b0;
    // Spurious starts while busy
    repeat (2) @(negedge clk);
    base_addr_i = 12'h0F0; num_tiles_i = 8'd5; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    wait_done();
    repeat (10) @(negedge clk);
    chk("post_n_reads", 64'(rd_addr.size()),  64'd4);
    chk("post_n_beats", 64'(bt_data.size()),  64'd4);
    chk("post_n_done",  64'(done_cyc.size()), 64'd1);
    if (rd_addr.size() == 4 && bt_data.size() == 4) begin
      chk("post_first_addr",  64'(rd_addr[0]), 64'h040);
      chk("post_first_cycle", 64'(rd_cyc[0]),  64'(k + 2));
      chk("post_last_addr",   64'(rd_addr[3]), 64'h043);
      chk("post_last_data",   64'(bt_data[3]), 64'(row_of(12'h043)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/weight_tile_sender.md
WEIGHT_TILE_SENDER -- requirements
Module: weight_tile_sender

Interface
REQ-001 Parameter: MUL_SIZE, default 8, rows per tile and weights per row.
REQ-002 Parameter: W_BITS, default 8, bits per weight.
REQ-003 Parameter: ADDR_W, default 12, weight-memory address width.
REQ-004 Port: clk_i, input, 1, single clock; all logic on rising edge.
REQ-005 Port: rst_i, input, 1, reset; asynchronous, active-low.
REQ-006 Port: start_i, input, 1, single-cycle job start pulse.
REQ-007 Port: base_addr_i, input, ADDR_W, first row address; sampled with start_i.
REQ-008 Port: num_tiles_i, input, 8, tile count; sampled with start_i.
REQ-009 Port: request_data_i, input, 1, weight FIFO ready-for-tile request.
REQ-010 Port: mem_rd_en_o, output, 1, weight-memory read strobe.
REQ-011 Port: mem_addr_o, output, ADDR_W, weight-memory row address.
REQ-012 Port: mem_data_i, input, MUL_SIZE x W_BITS, row data, valid one cycle after mem_rd_en_o.
REQ-013 Port: data_o, output, MUL_SIZE x W_BITS, row to weight FIFO.
REQ-014 Port: sending_data_o, output, 1, data_o carries a valid row this cycle.
REQ-015 Port: busy_o, output, 1, job in progress.
REQ-016 Port: done_o, output, 1, single-cycle job-complete pulse.

Function
REQ-017 The FSM SHALL use states IDLE, ARM, BURST, DRAIN.
REQ-018 IDLE: start_i high SHALL latch base_addr_i and num_tiles_i, then go to DRAIN if num_tiles_i==0, else ARM.
REQ-019 start_i SHALL be ignored outside IDLE.
REQ-020 ARM: request_data_i high at a clock edge SHALL move the FSM to BURST; low keeps it in ARM indefinitely.
REQ-021 BURST SHALL last exactly MUL_SIZE cycles: mem_rd_en_o=1 each cycle; mem_addr_o = running address, +1 per cycle, modulo 2^ADDR_W.
REQ-022 Once BURST starts, the tile SHALL complete even if request_data_i drops.
REQ-023 At the last BURST cycle, if tiles remain and request_data_i=1, the FSM SHALL stay in BURST for the next tile with no gap cycle.
REQ-024 At the last BURST cycle, if tiles remain and request_data_i=0, the FSM SHALL go to ARM.
REQ-025 At the last BURST cycle of the final tile, the FSM SHALL go to DRAIN.
REQ-026 Row addresses SHALL be contiguous across tiles: tile t row r reads base + t*MUL_SIZE + r, wrapping modulo 2^ADDR_W.
REQ-027 data_o and sending_data_o SHALL be registered: a read issued in cycle c appears in cycle c+2 with sending_data_o=1.
REQ-028 sending_data_o=0 SHALL hold data_o at its last value.
REQ-029 DRAIN SHALL wait until the output pipeline is empty, then assert done_o for one cycle and return to IDLE.
REQ-030 done_o SHALL occur exactly one cycle after the final sending_data_o beat; for a zero-tile job, two cycles after start.
REQ-031 busy_o SHALL be 1 from the cycle after start acceptance through the done_o cycle inclusive, else 0.
REQ-032 mem_rd_en_o SHALL be 0 in all states except BURST.

Reset
REQ-033 rst_i low SHALL immediately force state IDLE, all counters and latched values 0, mem_rd_en_o=0, mem_addr_o=0, data_o=0, sending_data_o=0, busy_o=0, done_o=0.
REQ-034 Reset mid-BURST or mid-DRAIN SHALL abort the job with no further beats or done_o; a new start_i is accepted in the first cycle after release.

Verification
REQ-035 MUL_SIZE=4, base=0x010, tiles=1, request held 1 -> reads 0x010..0x013 in four consecutive cycles; four beats two cycles later matching memory; done_o one cycle after the last beat.
REQ-036 tiles=3, request held 1 -> 12 consecutive reads 0x010..0x01B, no gap; 12 consecutive beats; single done_o pulse.
REQ-037 tiles=2; request drops after 2nd row of tile 0 and stays low 5 cycles -> tile 0 completes all 4 beats; FSM waits in ARM; tile 1 starts the edge after request returns.
REQ-038 base=0xFFE, tiles=1 -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-039 tiles=0 -> no mem_rd_en_o, no beats; done_o two cycles after start; busy_o high exactly one cycle.
REQ-040 rst_i low during the 3rd BURST cycle -> all outputs 0 at once, no done_o; a following 1-tile start completes normally; extra start_i pulses while busy change nothing.
